// File: rtl/data_mem_ctrl.sv
// RV32I byte-addressed data memory with valid/ready request and response handshakes.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module data_mem_ctrl #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam longint unsigned LIMIT = longint'(DEPTH) * 4;

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("data_mem_ctrl: DATA_WIDTH must be 32");
   end
   if (LIMIT > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
      $error("data_mem_ctrl: DEPTH*4 exceeds the byte address space");
   end

   typedef enum logic {IDLE, RESP} state_t;

   state_t           state_q;
   logic             rsp_valid_q;
   logic [31:0]      rsp_rdata_q;
   logic             rsp_err_q;
   logic [31:0]      mem_q [DEPTH];

   logic             accept;
   logic [1:0]       lane;
   logic [1:0]       eff_lane;
   logic [IDX_W-1:0] widx;
   logic             range_err;
   logic             misalign;
   logic             err_d;
   logic             wr_en;
   logic [3:0]       be;
   logic [31:0]      wdata_rep;
   logic [31:0]      rd_shift;
   logic [31:0]      rdata_d;

   function automatic logic [31:0] load_ext(input logic [31:0] sh, input logic [1:0] size,
                                            input logic uns);
      case (size)
         2'b00:   load_ext = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   load_ext = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   assign req_ready = !rsp_valid_q || rsp_ready;
   assign accept    = req_valid && req_ready;
   assign lane      = req_addr[1:0];
   assign widx      = req_addr[IDX_W+1:2];
   assign range_err = (64'(req_addr) >= LIMIT);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = (req_size == 2'b01 && lane[0]) || (req_size == 2'b10 && lane != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign err_d = range_err || (req_size == 2'b11) || misalign;
   assign wr_en = accept && req_we && !err_d;

   // Lane selection after force-alignment; with trapping enabled the aligned lane is only used on non-faulting requests.
   always_comb begin
      eff_lane  = lane;
      be        = 4'b1111;
      wdata_rep = req_wdata;
      case (req_size)
         2'b00: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            eff_lane  = {lane[1], 1'b0};
            be        = 4'b0011 << {lane[1], 1'b0};
            wdata_rep = {2{req_wdata[15:0]}};
         end
         default: begin
            eff_lane = 2'b00;
         end
      endcase
   end

   assign rd_shift = mem_q[widx] >> {eff_lane, 3'b000};
   assign rdata_d  = (req_we || err_d) ? 32'b0 : load_ext(rd_shift, req_size, req_unsigned);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
   end

   // Single-entry response register; a drain and a new accept in the same cycle keep it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rdata_d;
                  rsp_err_q   <= err_d;
               end
            end
            RESP: begin
               if (accept) begin
                  rsp_rdata_q <= rdata_d;
                  rsp_err_q   <= err_d;
               end else if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl (DEPTH=256 so the range limit 0x400 is addressable).
module tb_data_mem_ctrl;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       tag;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Drive one request, queue its expected response, and hold it until accepted.
   task automatic send(input logic we, input logic [1:0] size, input logic uns, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input string tag);
      bit ok = 1'b0;
      int n  = 0;
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      exp_q.push_back('{er, ee, tag});
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk({31'b0, ok}, 32'd1, {tag, "_accept_timeout"});
      req_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk({31'b0, rsp_valid}, 32'd0, "unexpected_rsp");
         end else begin
            mon_e = exp_q.pop_front();
            chk(rsp_rdata, mon_e.rdata, {mon_e.tag, "_rdata"});
            chk({31'b0, rsp_err}, {31'b0, mon_e.err}, {mon_e.tag, "_err"});
         end
      end
   end

   initial begin
      rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk({31'b0, rsp_valid}, 32'd0, "rst_valid");
      chk(rsp_rdata, 32'd0, "rst_rdata");
      chk({31'b0, rsp_err}, 32'd0, "rst_err");
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk({31'b0, req_ready}, 32'd1, "rst_req_ready");

      send(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0, "lw0_after_rst");
      chk({31'b0, rsp_valid}, 32'd1, "latency_one_cycle");

      send(1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF7F01, 32'h0, 1'b0, "sw_010");
      send(1'b0, 2'b00, 1'b0, 12'h010, 32'h0, 32'h00000001, 1'b0, "lb_010");
      send(1'b0, 2'b00, 1'b0, 12'h011, 32'h0, 32'h0000007F, 1'b0, "lb_011");
      send(1'b0, 2'b00, 1'b0, 12'h012, 32'h0, 32'hFFFFFFFF, 1'b0, "lb_012");
      send(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, "lb_013");
      send(1'b0, 2'b00, 1'b1, 12'h012, 32'h0, 32'h000000FF, 1'b0, "lbu_012");

      send(1'b1, 2'b10, 1'b0, 12'h020, 32'hAAAAAAAA, 32'h0, 1'b0, "sw_020");
      send(1'b1, 2'b01, 1'b0, 12'h022, 32'hFFFF1234, 32'h0, 1'b0, "sh_022");
      send(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'h1234AAAA, 1'b0, "lw_020");
      send(1'b0, 2'b01, 1'b1, 12'h022, 32'h0, 32'h00001234, 1'b0, "lhu_022");
      send(1'b0, 2'b01, 1'b0, 12'h020, 32'h0, 32'hFFFFAAAA, 1'b0, "lh_020");
      send(1'b1, 2'b00, 1'b0, 12'h021, 32'hABCDEF55, 32'h0, 1'b0, "sb_021");
      send(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'h123455AA, 1'b0, "lw_020_after_sb");

      // Backpressure: hold the response for three cycles with a second request waiting.
      send(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h80FF7F01, 1'b0, "stall_lw");
      rsp_ready = 1'b0;
      req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b1; req_addr = 12'h010; req_wdata = '0;
      req_valid = 1'b1;
      exp_q.push_back('{32'h00007F01, 1'b0, "queued_lhu"});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({31'b0, rsp_valid}, 32'd1, "stall_valid");
         chk(rsp_rdata, 32'h80FF7F01, "stall_rdata");
         chk({31'b0, req_ready}, 32'd0, "stall_req_ready");
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({31'b0, req_ready}, 32'd1, "drain_req_ready");
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk({31'b0, rsp_valid}, 32'd1, "no_bubble_valid");
      @(posedge clk); #1;

      send(1'b1, 2'b10, 1'b0, 12'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, "sw_last_word");
      send(1'b0, 2'b10, 1'b0, 12'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, "lw_last_word");
      send(1'b1, 2'b10, 1'b0, 12'h400, 32'hDEADBEEF, 32'h0, 1'b1, "sw_out_of_range");
      send(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0, "lw0_unchanged");
      send(1'b0, 2'b10, 1'b0, 12'h400, 32'h0, 32'h0, 1'b1, "lw_out_of_range");
      send(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 32'h0, 1'b1, "load_size11");
      send(1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF, 32'h0, 1'b1, "store_size11");
      send(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h80FF7F01, 1'b0, "lw_010_after_size11");

`ifdef DMEM_MISALIGN_TRAP_EN
      send(1'b0, 2'b10, 1'b0, 12'h021, 32'h0, 32'h0, 1'b1, "lw_021_misaligned");
      send(1'b0, 2'b01, 1'b0, 12'h011, 32'h0, 32'h0, 1'b1, "lh_011_misaligned");
      send(1'b1, 2'b01, 1'b0, 12'h023, 32'h0000BEEF, 32'h0, 1'b1, "sh_023_misaligned");
      send(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'h123455AA, 1'b0, "lw_020_after_sh_023");
`else
      send(1'b0, 2'b10, 1'b0, 12'h021, 32'h0, 32'h123455AA, 1'b0, "lw_021_aligned");
      send(1'b0, 2'b01, 1'b0, 12'h011, 32'h0, 32'h00007F01, 1'b0, "lh_011_aligned");
      send(1'b1, 2'b01, 1'b0, 12'h023, 32'h0000BEEF, 32'h0, 1'b0, "sh_023_aligned");
      send(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'hBEEF55AA, 1'b0, "lw_020_after_sh_023");
`endif

      // Reset while a response is held: it is dropped and the array is cleared.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      send(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h80FF7F01, 1'b0, "dropped_by_reset");
      #2 rst_n = 1'b0;
      #1;
      chk({31'b0, rsp_valid}, 32'd0, "rst_mid_valid");
      chk(rsp_rdata, 32'd0, "rst_mid_rdata");
      exp_q.delete();
      @(posedge clk); #3 rst_n = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      send(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h0, 1'b0, "lw_010_after_rst");
      send(1'b0, 2'b10, 1'b0, 12'h3FC, 32'h0, 32'h0, 1'b0, "lw_3fc_after_rst");

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk(32'(exp_q.size()), 32'd0, "scoreboard_drained");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
